// File: rtl/veririsc_pkg.sv
// Shared definitions for the VeriRISC CPU: opcode and phase encodings plus
// the bundle of control strobes produced by the controller.
package veririsc_pkg;

  localparam int OPCODE_W = 3;
  localparam int PHASE_W  = 3;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t HLT = 3'd0;
  localparam opcode_t SKZ = 3'd1;
  localparam opcode_t ADD = 3'd2;
  localparam opcode_t AND = 3'd3;
  localparam opcode_t XOR = 3'd4;
  localparam opcode_t LDA = 3'd5;
  localparam opcode_t STO = 3'd6;
  localparam opcode_t JMP = 3'd7;

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic ld_ac;
    logic wr;
    logic data_e;
    logic halt;
  } ctrl_t;

  // Instructions that fetch an operand from memory into the accumulator.
  function automatic logic is_aluop(input opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Free-running 3-bit instruction phase counter; freezes while hold_i is high.
module phase_counter
  import veririsc_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold_i,
  output phase_e phase_o
);

  phase_e phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (!hold_i) phase_d = phase_e'(phase_q + 1'b1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= INST_ADDR;
    else        phase_q <= phase_d;
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/cpu_controller.sv
// VeriRISC instruction sequencer: phase counter, halted flag and the
// combinational per-phase strobe decode.
module cpu_controller
  import veririsc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                ld_pc,
  output logic                ld_ac,
  output logic                wr,
  output logic                data_e,
  output logic                halt,
  output logic [PHASE_W-1:0]  phase
);

  phase_e phase_cur;
  logic   halted_q, halted_d;
  ctrl_t  ctrl;
  logic   aluop;

  assign aluop = is_aluop(opcode);

  // Holding on halted_d keeps phase at OP_ADDR on the very edge that halts.
  phase_counter u_phase_counter (
    .clk     (clk),
    .rst_n   (rst),
    .hold_i  (halted_d),
    .phase_o (phase_cur)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) halted_q <= 1'b0;
    else      halted_q <= halted_d;
  end

  always_comb begin
    halted_d = halted_q;
    if (phase_cur == OP_ADDR && opcode == HLT) halted_d = 1'b1;
  end

  always_comb begin
    // NOTE: defaulting the whole strobe bundle first means no path through
    // the case can leave a bit unassigned, so no latch is inferred.
    ctrl = '0;
    if (halted_q) begin
      ctrl.halt = 1'b1;
    end else begin
      unique case (phase_cur)
        INST_ADDR:  ctrl.sel = 1'b1;
        INST_FETCH: begin
          ctrl.sel = 1'b1;
          ctrl.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          ctrl.sel   = 1'b1;
          ctrl.rd    = 1'b1;
          ctrl.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          ctrl.inc_pc = 1'b1;
          ctrl.halt   = (opcode == HLT);
        end
        OP_FETCH:   ctrl.rd = aluop;
        ALU_OP: begin
          ctrl.rd     = aluop;
          ctrl.inc_pc = (opcode == SKZ) && zero;
          ctrl.ld_pc  = (opcode == JMP);
          ctrl.data_e = (opcode == STO);
        end
        STORE: begin
          ctrl.rd     = aluop;
          ctrl.ld_pc  = (opcode == JMP);
          ctrl.ld_ac  = aluop;
          ctrl.wr     = (opcode == STO);
          ctrl.data_e = (opcode == STO);
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign sel    = ctrl.sel;
  assign rd     = ctrl.rd;
  assign ld_ir  = ctrl.ld_ir;
  assign inc_pc = ctrl.inc_pc;
  assign ld_pc  = ctrl.ld_pc;
  assign ld_ac  = ctrl.ld_ac;
  assign wr     = ctrl.wr;
  assign data_e = ctrl.data_e;
  assign halt   = ctrl.halt;
  assign phase  = phase_cur;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-phase strobe tables for each opcode,
// halt behaviour and asynchronous reset mid-instruction.
module tb_cpu_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;
  logic [8:0] strobes;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_controller dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  assign strobes = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
  localparam logic [8:0] S_RST  = 9'b100000000;
  localparam logic [8:0] S_F1   = 9'b110000000;
  localparam logic [8:0] S_LD   = 9'b111000000;
  localparam logic [8:0] S_INC  = 9'b000100000;
  localparam logic [8:0] S_RD   = 9'b010000000;
  localparam logic [8:0] S_NONE = 9'b000000000;
  localparam logic [8:0] S_HLTI = 9'b000100001;
  localparam logic [8:0] S_HALT = 9'b000000001;

  // Tables packed with phase 0 in the least significant 9 bits.
  localparam logic [71:0] T_ADD = {9'b010001000, S_RD, S_RD, S_INC, S_LD, S_LD, S_F1, S_RST};
  localparam logic [71:0] T_STO = {9'b000000110, 9'b000000010, S_NONE, S_INC, S_LD, S_LD, S_F1, S_RST};
  localparam logic [71:0] T_SKZ1 = {S_NONE, S_INC, S_NONE, S_INC, S_LD, S_LD, S_F1, S_RST};
  localparam logic [71:0] T_SKZ0 = {S_NONE, S_NONE, S_NONE, S_INC, S_LD, S_LD, S_F1, S_RST};
  localparam logic [71:0] T_JMP = {9'b000010000, 9'b000010000, S_NONE, S_INC, S_LD, S_LD, S_F1, S_RST};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Runs one instruction from phase 0; zero is z6 during ALU_OP, z_other elsewhere.
  task automatic run_pass(input string name, input logic [2:0] op, input logic z6,
                          input logic z_other, input logic [71:0] tbl);
    opcode = op;
    for (int p = 0; p < 8; p++) begin
      zero = (p == 6) ? z6 : z_other;
      #1;
      check($sformatf("%s phase p%0d", name, p), {13'd0, phase}, p[15:0]);
      check($sformatf("%s strobes p%0d", name, p), {7'd0, strobes}, {7'd0, tbl[p*9 +: 9]});
      if (p == 7 || (rd === 1'b1 && wr === 1'b1))
        check($sformatf("%s rd_wr_excl p%0d", name, p), {15'd0, rd & wr}, 16'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst    = 1'b0;
    opcode = 3'd2;
    zero   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset phase", {13'd0, phase}, 16'd0);
    check("reset strobes", {7'd0, strobes}, {7'd0, S_RST});
    rst = 1'b1;

    run_pass("ADD", 3'd2, 1'b0, 1'b0, T_ADD);
    run_pass("STO", 3'd6, 1'b0, 1'b0, T_STO);
    run_pass("SKZ_z1", 3'd1, 1'b1, 1'b1, T_SKZ1);
    // zero high outside ALU_OP must be ignored.
    run_pass("SKZ_z0", 3'd1, 1'b0, 1'b1, T_SKZ0);
    run_pass("JMP", 3'd7, 1'b0, 1'b0, T_JMP);

    opcode = 3'd0;
    zero   = 1'b0;
    for (int p = 0; p < 4; p++) begin
      #1;
      check($sformatf("HLT phase p%0d", p), {13'd0, phase}, p[15:0]);
      @(negedge clk);
    end
    check("HLT op_addr phase", {13'd0, phase}, 16'd4);
    check("HLT op_addr strobes", {7'd0, strobes}, {7'd0, S_HLTI});
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      if (c == 1) opcode = 3'd2;
      zero = c[0];
      #1;
      check($sformatf("halted phase c%0d", c), {13'd0, phase}, 16'd4);
      check($sformatf("halted strobes c%0d", c), {7'd0, strobes}, {7'd0, S_HALT});
      @(negedge clk);
    end

    rst = 1'b0;
    #2;
    check("halt reset phase", {13'd0, phase}, 16'd0);
    check("halt reset strobes", {7'd0, strobes}, {7'd0, S_RST});
    #2 rst = 1'b1;
    @(negedge clk);
    check("post-halt resume phase", {13'd0, phase}, 16'd1);
    check("post-halt resume strobes", {7'd0, strobes}, {7'd0, S_F1});

    repeat (6) @(negedge clk);
    check("pre-abort phase", {13'd0, phase}, 16'd7);
    check("pre-abort strobes", {7'd0, strobes}, {7'd0, 9'b010001000});
    #3 rst = 1'b0;
    #1;
    check("abort phase", {13'd0, phase}, 16'd0);
    check("abort ld_ac", {15'd0, ld_ac}, 16'd0);
    check("abort sel", {15'd0, sel}, 16'd1);
    @(negedge clk);
    check("abort held phase", {13'd0, phase}, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort resume phase", {13'd0, phase}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
